btn_repeat_conditioner: RTL

Multi-button front end that sits directly upstream of the cursor/number-mode command logic. It takes the raw Basys3 pushbuttons (C,U,D,L,R) and for each one produces a synchronized, debounced level and single-cycle press pulses. Pulses repeat automatically while a button is held, so the cursor and the selected number can be scrolled. Its pulse outputs are the per-button edge signals consumed by mode/command generation.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_repeat_channel.sv | 183 ++++++++++++++++++
 rtl/btn_repeat_conditioner.sv | 83 ++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the pushbutton conditioner.
//   btn_state_t : per-button repeat FSM state (IDLE, HELD, REPEAT)
//   BTN_*       : bit index of each Basys3 pushbutton in the button vectors
//   ACCEL_AFTER : repeat pulses before the faster interval applies (only used
//                 when BTN_REPEAT_ACCEL_EN is defined)
//   cnt_width() : width of a counter that must hold 0..limit, never below 1
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  localparam int ACCEL_AFTER = 8;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/btn_repeat_channel.sv
// btn_repeat_channel: one button's synchronizer, debouncer and repeat FSM.
// Optional macro: BTN_REPEAT_ACCEL_EN (halves the repeat interval after
// ACCEL_AFTER consecutive repeat pulses).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   tick_i       : shared 1 ms tick, one cycle wide
//   btn_raw_i    : asynchronous raw button
//   repeat_en_i  : 1 = auto-repeat allowed
//   level_o      : debounced level
//   pulse_o      : 1-cycle pulse on press and on each repeat
//   is_repeat_o  : qualifies pulse_o (1 = repeat, 0 = initial press)
module btn_repeat_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS      = 10,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic pulse_o,
  output logic is_repeat_o
);

  localparam int DEB_W    = cnt_width(DEBOUNCE_MS);
  localparam int HOLD_LIM = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
  localparam int HOLD_W   = cnt_width(HOLD_LIM);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  btn_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pulse_q, pulse_d;
  logic              is_rep_q, is_rep_d;
  logic              rise, fall, delay_hit, period_hit;
  int                period_lim;

`ifdef BTN_REPEAT_ACCEL_EN
  localparam int FAST_PERIOD = (REPEAT_PERIOD_MS / 2 < 1) ? 1 : REPEAT_PERIOD_MS / 2;
  localparam int REP_W       = cnt_width(ACCEL_AFTER);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  assign period_lim = (int'(rep_cnt_q) >= ACCEL_AFTER) ? FAST_PERIOD : REPEAT_PERIOD_MS;
`else
  assign period_lim = REPEAT_PERIOD_MS;
`endif

  // Debounce: any cycle where the synchronized input agrees with the level
  // restarts the count, so only an unbroken run of ticks flips the level.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (tick_i) begin
      if (int'(deb_cnt_q) + 1 >= DEBOUNCE_MS) begin
        level_d   = ~level_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Edges are taken from the next level so the press pulse and the new level
  // appear on the same cycle.
  assign rise       = level_d & ~level_q;
  assign fall       = ~level_d & level_q;
  assign delay_hit  = tick_i && repeat_en_i && (int'(hold_cnt_q) + 1 >= REPEAT_DELAY_MS);
  assign period_hit = tick_i && repeat_en_i && (int'(hold_cnt_q) + 1 >= period_lim);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      pulse_q    <= 1'b0;
      is_rep_q   <= 1'b0;
`ifdef BTN_REPEAT_ACCEL_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= pulse_d;
      is_rep_q   <= is_rep_d;
`ifdef BTN_REPEAT_ACCEL_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  // Next-state logic. A release wins over everything, including a repeat
  // that falls due on the same tick.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
`ifdef BTN_REPEAT_ACCEL_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    if (fall) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
`ifdef BTN_REPEAT_ACCEL_EN
      rep_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d    = HELD;
            hold_cnt_d = '0;
          end
        end
        HELD: begin
          if (delay_hit) begin
            state_d    = REPEAT;
            hold_cnt_d = '0;
`ifdef BTN_REPEAT_ACCEL_EN
            rep_cnt_d  = REP_W'(1);
`endif
          end else if (tick_i && int'(hold_cnt_q) < HOLD_LIM) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!repeat_en_i) begin
            state_d    = HELD;
            hold_cnt_d = '0;
`ifdef BTN_REPEAT_ACCEL_EN
            rep_cnt_d  = '0;
`endif
          end else if (period_hit) begin
            hold_cnt_d = '0;
`ifdef BTN_REPEAT_ACCEL_EN
            if (int'(rep_cnt_q) < ACCEL_AFTER) rep_cnt_d = rep_cnt_q + 1'b1;
`endif
          end else if (tick_i) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic, registered above.
  always_comb begin
    pulse_d  = 1'b0;
    is_rep_d = 1'b0;
    if (!fall) begin
      case (state_q)
        IDLE:   pulse_d = rise;
        HELD: begin
          pulse_d  = delay_hit;
          is_rep_d = delay_hit;
        end
        REPEAT: begin
          pulse_d  = period_hit;
          is_rep_d = period_hit;
        end
        default: ;
      endcase
    end
  end

  assign level_o     = level_q;
  assign pulse_o     = pulse_q;
  assign is_repeat_o = is_rep_q;

endmodule

// File: rtl/btn_repeat_conditioner.sv
// btn_repeat_conditioner: synchronizes and debounces the pushbuttons and
// produces press/auto-repeat pulses for the cursor and number-mode logic.
// Optional macro: BTN_REPEAT_ACCEL_EN (faster repeats after a long hold).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   btn_raw       : raw asynchronous buttons (bit 0=C,1=U,2=D,3=L,4=R)
//   repeat_mask   : per-button auto-repeat enable
//   btn_level     : debounced levels
//   btn_pulse     : 1-cycle pulses on press and repeat
//   btn_is_repeat : 1 when the matching btn_pulse is a repeat
//   tick_1ms      : shared 1 ms prescaler tick
module btn_repeat_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN            = 5,
  parameter int CLK_HZ           = 100_000_000,
  parameter int DEBOUNCE_MS      = 10,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_mask,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_is_repeat,
  output logic             tick_1ms
);

  localparam int PRE_MAX = CLK_HZ / 1000 - 1;
  localparam int PRE_W   = cnt_width(PRE_MAX);

  generate
    if (CLK_HZ < 1000) begin : g_bad_clk
      $error("btn_repeat_conditioner: CLK_HZ must be at least 1000");
    end
    if (N_BTN < 1 || DEBOUNCE_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_PERIOD_MS < 1) begin : g_bad_param
      $error("btn_repeat_conditioner: all parameters must be at least 1");
    end
  endgenerate

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q;
  logic             pre_wrap;

  assign pre_wrap  = (pre_cnt_q == PRE_W'(PRE_MAX));
  assign pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + 1'b1;

  // The tick is registered, so it is high on the cycle after the count
  // sits at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= pre_wrap;
    end
  end

  assign tick_1ms = tick_q;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_repeat_channel #(
        .DEBOUNCE_MS      (DEBOUNCE_MS),
        .REPEAT_DELAY_MS  (REPEAT_DELAY_MS),
        .REPEAT_PERIOD_MS (REPEAT_PERIOD_MS)
      ) u_chan (
        .clk         (clk),
        .reset       (reset),
        .tick_i      (tick_q),
        .btn_raw_i   (btn_raw[gi]),
        .repeat_en_i (repeat_mask[gi]),
        .level_o     (btn_level[gi]),
        .pulse_o     (btn_pulse[gi]),
        .is_repeat_o (btn_is_repeat[gi])
      );
    end
  endgenerate

endmodule
